// File: rtl/counter_pkg.sv
// Shared types for the counter arbiter: opcodes, FSM states and opcode decode.
package counter_pkg;

  localparam int unsigned OPW = 2;

  typedef enum logic [OPW-1:0] {
    OP_INC  = 2'b00,
    OP_LOAD = 2'b01,
    OP_READ = 2'b10
  } op_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_OWNED = 1'b1
  } state_e;

  // Reserved encoding 11 folds onto READ.
  function automatic op_e decode_op(input logic [OPW-1:0] raw);
    case (raw)
      2'b00:   return OP_INC;
      2'b01:   return OP_LOAD;
      default: return OP_READ;
    endcase
  endfunction

endpackage

// File: rtl/counter_arbiter_if.sv
// Request/response bundle between client blocks and the shared counter arbiter.
interface counter_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned WIDTH   = 8
);
  import counter_pkg::*;

  localparam int unsigned IDW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]       req_valid;
  logic [OPW*NUM_REQ-1:0]   req_op;
  logic [NUM_REQ-1:0]       req_lock;
  logic [WIDTH*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]       req_ready;
  logic                     rsp_valid;
  logic [IDW-1:0]           rsp_id;
  logic [WIDTH-1:0]         rsp_data;
  logic                     rsp_wrap;
  logic [WIDTH-1:0]         count;

  modport master (
    output req_valid, req_op, req_lock, req_data,
    input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_wrap, count
  );

  modport slave (
    input  req_valid, req_op, req_lock, req_data,
    output req_ready, rsp_valid, rsp_id, rsp_data, rsp_wrap, count
  );

endinterface

// File: rtl/counter_arbiter_rr_pick.sv
// Combinational round-robin first-one search starting at ptr and wrapping.
module rr_pick #(
  parameter  int unsigned N  = 4,
  localparam int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx
);

  logic [IW-1:0] pos;

  // Scan from the farthest offset down so the closest-to-ptr requester wins.
  always_comb begin
    grant = '0;
    idx   = '0;
    pos   = '0;
    for (int k = int'(N) - 1; k >= 0; k--) begin
      pos = IW'((int'(ptr) + k) % int'(N));
      if (req[pos]) begin
        grant      = '0;
        grant[pos] = 1'b1;
        idx        = pos;
      end
    end
  end

endmodule

// File: rtl/counter_arbiter.sv
// Shared step/overwrite counter with round-robin arbitration, lock-based
// ownership and a registered one-cycle tagged response.
module counter_arbiter
  import counter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned WIDTH   = 8
) (
  input  logic             clk,
  input  logic             rst,
  counter_arbiter_if.slave bus
);

  localparam int unsigned IDW = $clog2(NUM_REQ);

  state_e           state, state_nxt;
  logic [IDW-1:0]   owner, owner_nxt;
  logic [IDW-1:0]   rr_ptr, rr_ptr_nxt;
  logic [WIDTH-1:0] count_q, count_nxt;
  logic             rsp_valid_q, rsp_valid_nxt;
  logic [IDW-1:0]   rsp_id_q, rsp_id_nxt;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_nxt;
  logic             rsp_wrap_q, rsp_wrap_nxt;

  logic [NUM_REQ-1:0] pick_grant;
  logic [IDW-1:0]     pick_idx;
  logic [NUM_REQ-1:0] ready;
  logic [IDW-1:0]     gid;
  op_e                op_arr   [NUM_REQ];
  logic [WIDTH-1:0]   data_arr [NUM_REQ];

  rr_pick #(.N(NUM_REQ)) u_pick (
    .req   (bus.req_valid),
    .ptr   (rr_ptr),
    .grant (pick_grant),
    .idx   (pick_idx)
  );

  // Unpack per-requester opcode and load data.
  always_comb begin
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      op_arr[i]   = decode_op(bus.req_op[OPW*i +: OPW]);
      data_arr[i] = bus.req_data[WIDTH*i +: WIDTH];
    end
  end

  // Grant selection, counter update and FSM next state.
  always_comb begin
    state_nxt     = state;
    owner_nxt     = owner;
    rr_ptr_nxt    = rr_ptr;
    count_nxt     = count_q;
    rsp_valid_nxt = 1'b0;
    rsp_id_nxt    = rsp_id_q;
    rsp_data_nxt  = rsp_data_q;
    rsp_wrap_nxt  = rsp_wrap_q;
    ready         = '0;
    gid           = owner;

    case (state)
      ST_IDLE: begin
        ready = pick_grant;
        gid   = pick_idx;
      end
      ST_OWNED: begin
        ready = bus.req_valid & (NUM_REQ'(1) << owner);
        gid   = owner;
      end
      default: ;
    endcase

    if (|ready) begin
      rsp_wrap_nxt = 1'b0;
      case (op_arr[gid])
        OP_INC: begin
          count_nxt    = count_q + WIDTH'(1);
          rsp_wrap_nxt = (count_q == {WIDTH{1'b1}});
        end
        OP_LOAD: count_nxt = data_arr[gid];
        default: ;
      endcase
      rsp_valid_nxt = 1'b1;
      rsp_id_nxt    = gid;
      rsp_data_nxt  = count_nxt;

      // Pointer only advances on arbitrated transfers, never on owner traffic.
      if (state == ST_IDLE) begin
        rr_ptr_nxt = (gid == IDW'(NUM_REQ - 1)) ? '0 : gid + IDW'(1);
        if (bus.req_lock[gid]) begin
          state_nxt = ST_OWNED;
          owner_nxt = gid;
        end
      end else if (!bus.req_lock[gid]) begin
        state_nxt = ST_IDLE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      owner       <= '0;
      rr_ptr      <= '0;
      count_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
      rsp_wrap_q  <= 1'b0;
    end else begin
      state       <= state_nxt;
      owner       <= owner_nxt;
      rr_ptr      <= rr_ptr_nxt;
      count_q     <= count_nxt;
      rsp_valid_q <= rsp_valid_nxt;
      rsp_id_q    <= rsp_id_nxt;
      rsp_data_q  <= rsp_data_nxt;
      rsp_wrap_q  <= rsp_wrap_nxt;
    end
  end

  assign bus.req_ready = ready;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_wrap  = rsp_wrap_q;
  assign bus.count     = count_q;

endmodule

// File: tb/tb_counter_arbiter.sv
// Directed table-driven bench for counter_arbiter with hand-written reset corner cases.
module tb_counter_arbiter;

  typedef struct {
    logic [3:0]  valid;
    logic [7:0]  op;
    logic [3:0]  lock;
    logic [31:0] data;
    logic [3:0]  ready;
    logic        rv;
    logic [1:0]  id;
    logic [7:0]  rdata;
    logic        wrap;
    logic [7:0]  cnt;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   total  = 0;
  int   passed = 0;

  counter_arbiter_if #(.NUM_REQ(4), .WIDTH(8)) bus ();

  counter_arbiter #(.NUM_REQ(4), .WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic vec_t mk(input logic [3:0] valid, input logic [7:0] op, input logic [3:0] lock,
                              input logic [31:0] data, input logic [3:0] ready, input logic rv,
                              input logic [1:0] id, input logic [7:0] rdata, input logic wrap,
                              input logic [7:0] cnt);
    vec_t v;
    v.valid = valid; v.op = op; v.lock = lock; v.data = data; v.ready = ready;
    v.rv = rv; v.id = id; v.rdata = rdata; v.wrap = wrap; v.cnt = cnt;
    return v;
  endfunction

  task automatic drive(input logic [3:0] valid, input logic [7:0] op, input logic [3:0] lock,
                       input logic [31:0] data);
    bus.req_valid = valid;
    bus.req_op    = op;
    bus.req_lock  = lock;
    bus.req_data  = data;
  endtask

  vec_t vecs[$];

  initial begin
    // Expected values assume rr_ptr/state evolve as annotated per line.
    vecs.push_back(mk(4'h1, 8'h00, 4'h0, 32'h0,        4'h1, 1, 2'd0, 8'h01, 0, 8'h01)); // ptr->1
    vecs.push_back(mk(4'h1, 8'h00, 4'h0, 32'h0,        4'h1, 1, 2'd0, 8'h02, 0, 8'h02));
    vecs.push_back(mk(4'h1, 8'h00, 4'h0, 32'h0,        4'h1, 1, 2'd0, 8'h03, 0, 8'h03));
    vecs.push_back(mk(4'hF, 8'hAA, 4'h0, 32'h0,        4'h2, 1, 2'd1, 8'h03, 0, 8'h03)); // rotation
    vecs.push_back(mk(4'hF, 8'hAA, 4'h0, 32'h0,        4'h4, 1, 2'd2, 8'h03, 0, 8'h03));
    vecs.push_back(mk(4'hF, 8'hAA, 4'h0, 32'h0,        4'h8, 1, 2'd3, 8'h03, 0, 8'h03));
    vecs.push_back(mk(4'hF, 8'hAA, 4'h0, 32'h0,        4'h1, 1, 2'd0, 8'h03, 0, 8'h03)); // ptr wrap 3->0
    vecs.push_back(mk(4'h4, 8'h10, 4'h0, 32'h00FF0000, 4'h4, 1, 2'd2, 8'hFF, 0, 8'hFF)); // LOAD FF
    vecs.push_back(mk(4'h4, 8'h00, 4'h0, 32'h0,        4'h4, 1, 2'd2, 8'h00, 1, 8'h00)); // INC wraps
    vecs.push_back(mk(4'h0, 8'h00, 4'h0, 32'h0,        4'h0, 0, 2'd0, 8'h00, 0, 8'h00)); // idle
    vecs.push_back(mk(4'h1, 8'hAA, 4'h0, 32'h0,        4'h1, 1, 2'd0, 8'h00, 0, 8'h00)); // ptr->1
    vecs.push_back(mk(4'hF, 8'hA2, 4'h2, 32'h0,        4'h2, 1, 2'd1, 8'h01, 0, 8'h01)); // lock by 1
    vecs.push_back(mk(4'hD, 8'hA2, 4'h2, 32'h0,        4'h0, 0, 2'd0, 8'h00, 0, 8'h01)); // owner idle stalls others
    vecs.push_back(mk(4'hF, 8'hA6, 4'h0, 32'h0000AA00, 4'h2, 1, 2'd1, 8'hAA, 0, 8'hAA)); // owner LOAD+release
    vecs.push_back(mk(4'hF, 8'hAA, 4'h0, 32'h0,        4'h4, 1, 2'd2, 8'hAA, 0, 8'hAA)); // grant moves to 2
    vecs.push_back(mk(4'h8, 8'hC0, 4'h0, 32'h0,        4'h8, 1, 2'd3, 8'hAA, 0, 8'hAA)); // reserved op
    vecs.push_back(mk(4'h4, 8'h10, 4'h4, 32'h00CC0000, 4'h4, 1, 2'd2, 8'hCC, 0, 8'hCC)); // owned by 2, CC

    rst = 1'b1;
    drive(4'h0, 8'h00, 4'h0, 32'h0);
    @(posedge clk); #1;
    check("reset_count", 32'(bus.count), 32'h0);
    check("reset_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    check("reset_rsp_id", 32'(bus.rsp_id), 32'h0);
    check("reset_rsp_data", 32'(bus.rsp_data), 32'h0);
    check("reset_ready", 32'(bus.req_ready), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[n]) begin
      @(negedge clk);
      drive(vecs[n].valid, vecs[n].op, vecs[n].lock, vecs[n].data);
      #1;
      check($sformatf("v%0d_ready", n), 32'(bus.req_ready), 32'(vecs[n].ready));
      @(posedge clk); #1;
      check($sformatf("v%0d_rsp_valid", n), 32'(bus.rsp_valid), 32'(vecs[n].rv));
      if (vecs[n].rv) begin
        check($sformatf("v%0d_rsp_id", n), 32'(bus.rsp_id), 32'(vecs[n].id));
        check($sformatf("v%0d_rsp_data", n), 32'(bus.rsp_data), 32'(vecs[n].rdata));
        check($sformatf("v%0d_rsp_wrap", n), 32'(bus.rsp_wrap), 32'(vecs[n].wrap));
      end
      check($sformatf("v%0d_count", n), 32'(bus.count), 32'(vecs[n].cnt));
    end

    // Owner 2 READs keeping lock, then reset lands while its response is visible.
    @(negedge clk);
    drive(4'h4, 8'h20, 4'h4, 32'h0);
    #1;
    check("owned_ready", 32'(bus.req_ready), 32'h4);
    @(posedge clk); #1;
    check("owned_rsp_valid", 32'(bus.rsp_valid), 32'h1);
    check("owned_rsp_data", 32'(bus.rsp_data), 32'hCC);
    rst = 1'b1;
    #1;
    check("midrst_count", 32'(bus.count), 32'h0);
    check("midrst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    check("midrst_rsp_data", 32'(bus.rsp_data), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    drive(4'hF, 8'hAA, 4'h0, 32'h0);
    #1;
    check("postrst_ready", 32'(bus.req_ready), 32'h1);
    @(posedge clk); #1;
    check("postrst_rsp_valid", 32'(bus.rsp_valid), 32'h1);
    check("postrst_rsp_id", 32'(bus.rsp_id), 32'h0);
    check("postrst_rsp_data", 32'(bus.rsp_data), 32'h0);
    @(negedge clk);
    drive(4'h0, 8'h00, 4'h0, 32'h0);
    @(posedge clk); #1;
    check("rsp_single_cycle", 32'(bus.rsp_valid), 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/counter_arbiter.md
# counter_arbiter

Round-robin arbiter and sequencer that shares one WIDTH-bit step/overwrite counter between NUM_REQ requesters. Each requester issues INC, LOAD or READ operations over a valid/ready handshake and receives a tagged one-cycle response carrying the post-operation count. It sits between client blocks and the shared count register. Client blocks never drive the counter's mode or write data directly.

## Interface
Parameters:
- NUM_REQ, 4: number of requesters, from 2 to 8.
- WIDTH, 8: counter and data width.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request strobe.
- req_op  in  2*NUM_REQ  per-requester opcode, packed with requester i at [2i+1:2i]. Encoding: 00 INC, 01 LOAD, 10 READ, 11 reserved (treated as READ).
- req_lock  in  NUM_REQ  requests ownership retention after this operation.
- req_data  in  WIDTH*NUM_REQ  LOAD value for requester i at [WIDTH*i +: WIDTH].
- req_ready  out  NUM_REQ  one-hot grant; combinational from req_valid, req_lock state and the pointer.
- rsp_valid  out  1  single-cycle response strobe.
- rsp_id  out  $clog2(NUM_REQ)  index of the requester being answered.
- rsp_data  out  WIDTH  count after the operation.
- rsp_wrap  out  1  the answered INC wrapped from all-ones to 0.
- count  out  WIDTH  live counter value.

## Operation
- **Transfer:** occurs on a rising edge where req_valid[i] and req_ready[i] are both 1. At most one transfer per cycle.
- **INC:** count <= count+1, modulo 2^WIDTH.
- **LOAD:** count <= req_data[i].
- **READ:** count unchanged.
- **States:**
  - IDLE: round-robin arbitration. Search starts at rr_ptr and wraps. The first valid requester is granted.
  - OWNED(owner): only req_ready[owner] may assert; other requesters stall regardless of priority.
- **Transitions:**
  - IDLE → OWNED(i) on a transfer from i with req_lock[i]=1.
  - OWNED → OWNED on an owner transfer with req_lock=1.
  - OWNED → IDLE on an owner transfer with req_lock=0.
  - No timeout. The owner holding valid=0 keeps ownership.
- **rr_ptr:** on every transfer, rr_ptr <= (granted id + 1) mod NUM_REQ. On wrap, id NUM_REQ-1 → 0. It is not updated in OWNED.
- **Reserved opcode 11:** behaves exactly as READ.
- **Width rules:** rsp_wrap=1 only for INC with pre-count = {WIDTH{1'b1}}. LOAD of all-ones followed by INC yields 0 with rsp_wrap=1.
- **Reset values** (asynchronous, effective immediately): count=0, rr_ptr=0, state IDLE, rsp_valid=0, rsp_id=0, rsp_data=0, rsp_wrap=0. req_ready follows combinationally; it is all-zero while req_valid=0.
- **Reset mid-operation:** an in-flight response is dropped and ownership is released.

## Timing
- **Grant:** req_ready is asserted in the same cycle as req_valid (zero-cycle grant), with no combinational path from req_ready back into req_valid.
- **Count update:** count reflects the operation one cycle after the transfer edge.
- **Response:** rsp_valid/rsp_id/rsp_data/rsp_wrap are registered and asserted for exactly one cycle, the cycle after the transfer. rsp_data equals the new count.
- **Throughput:** back-to-back transfers give one response per cycle with no bubbles.
- **Stall:** a requester with valid=1 and ready=0 must hold op, lock and data stable.

## Structure
- **Shared package `counter_pkg`:**
  - op enum: OP_INC, OP_LOAD, OP_READ.
  - state enum: ST_IDLE, ST_OWNED.
  - localparam OPW=2.
- **Sub-module `rr_pick`:** combinational round-robin first-one search. Inputs: request vector and pointer. Outputs: one-hot grant and index.
- **Top:** the count register, the FSM and the response registers.

## Test plan
1. **Reset and single INC:** reset, then requester 0 INC ×3 → rsp_data 1,2,3; rsp_id=0; count=3.
2. **Round-robin rotation:** all 4 requesters hold valid with READ → grants in order 0,1,2,3,0,… with one response per cycle.
3. **LOAD then wrap:** requester 2 LOADs 8'hFF, then INCs → rsp_data=8'h00, rsp_wrap=1, count=0.
4. **Lock:** requester 1 INC with lock=1 while requesters 0, 2 and 3 are valid → only 1 is granted. Requester 1 then LOADs 8'hAA with lock=0 → grant moves to 2; rsp_data=8'hAA, then 8'hAA on 2's READ.
5. **Reserved opcode:** requester 3 issues op 11 → count unchanged; rsp_data equals the current count.
6. **Mid-operation reset:** assert rst while in OWNED with count=8'hCC → count=0, rsp_valid=0, state IDLE; requester 0 is granted first afterwards.
